muldiv_unit: RTL and testbench

Iterative, parametrised multiply/divide unit implementing the RV32M/RV64M operation set. It sits beside the single-cycle ALU in the execute stage: the hazard unit stalls the pipeline while `busy` is high and captures `result` on `done`. One operation is in flight at a time, and every operation has the same fixed latency.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_operand_prep.sv | 50 +++++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// funct3 operation codes and the sequencer state type.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  // funct3 bit 2 separates the divide group from the multiply group.
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: magnitudes, result-negate flag and
// divide special-case flags (flags exist only when MULDIV_DIV_EN is defined).
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg_result
`ifdef MULDIV_DIV_EN
  ,
  output logic            div_zero,
  output logic            div_ovf
`endif
);

  logic signed_a;
  logic signed_b;
  logic sign_a;
  logic sign_b;

  // MUL only keeps the low half, which is identical for any signedness.
  assign signed_a = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                    (op == OP_DIV) || (op == OP_REM);
  assign signed_b = (op == OP_MUL) || (op == OP_MULH) ||
                    (op == OP_DIV) || (op == OP_REM);

  assign sign_a = signed_a & srca[XLEN-1];
  assign sign_b = signed_b & srcb[XLEN-1];

  // The most negative value maps onto 2^(XLEN-1), which still fits unsigned.
  assign mag_a = sign_a ? -srca : srca;
  assign mag_b = sign_b ? -srcb : srcb;

  // Remainder follows the dividend; everything else follows the operand XOR.
  assign neg_result = (op == OP_REM) ? sign_a : (sign_a ^ sign_b);

`ifdef MULDIV_DIV_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  assign div_zero = is_div_op(op) && (srcb == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                    (srca == MOST_NEG) && (&srcb);
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit, fixed XLEN+2 cycle latency per operation.
// Divider datapath is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   mag_a_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   final_val;

  logic [XLEN-1:0]   prep_mag_a;
  logic [XLEN-1:0]   prep_mag_b;
  logic              prep_neg;

`ifdef MULDIV_DIV_EN
  logic              prep_div_zero;
  logic              prep_div_ovf;
  logic [XLEN-1:0]   mag_b_q;
  logic [XLEN-1:0]   srca_q;
  logic              div_zero_q;
  logic              div_ovf_q;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   diff;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
`endif

  muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
    .op         (op),
    .srca       (srca),
    .srcb       (srcb),
    .mag_a      (prep_mag_a),
    .mag_b      (prep_mag_b),
    .neg_result (prep_neg)
`ifdef MULDIV_DIV_EN
    ,
    .div_zero   (prep_div_zero),
    .div_ovf    (prep_div_ovf)
`endif
  );

  assign busy = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CALC;
      ST_CALC:  if (cnt == CNT_LAST) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  // acc = {high/partial remainder, low/multiplier-or-quotient}.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a_q} : '0);
    acc_nxt = {mul_sum, acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff   = {1'b0, rem_sh} - {2'b00, mag_b_q};
    if (is_div_op(op_q)) begin
      // A kept remainder is always below the divisor, so XLEN bits suffice.
      if (diff[XLEN+1]) acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else              acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
`else
    if (is_div_op(op_q)) acc_nxt = acc;
`endif
  end

  // FINAL result selection with sign correction and forced special cases.
  always_comb begin
    prod      = neg_q ? -acc : acc;
    final_val = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    quo = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (is_div_op(op_q)) begin
      final_val = op_q[1] ? rem : quo;
      if (div_zero_q)     final_val = op_q[1] ? srca_q : '1;
      else if (div_ovf_q) final_val = op_q[1] ? '0 : srca_q;
    end
`else
    if (is_div_op(op_q)) final_val = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      op_q    <= OP_MUL;
      mag_a_q <= '0;
      neg_q   <= 1'b0;
      acc     <= '0;
      done    <= 1'b0;
      result  <= '0;
`ifdef MULDIV_DIV_EN
      mag_b_q    <= '0;
      srca_q     <= '0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (!flush) begin
        case (state)
          ST_IDLE: if (start) begin
            cnt     <= '0;
            op_q    <= op;
            mag_a_q <= prep_mag_a;
            neg_q   <= prep_neg;
            acc     <= is_div_op(op) ? {{XLEN{1'b0}}, prep_mag_a}
                                     : {{XLEN{1'b0}}, prep_mag_b};
`ifdef MULDIV_DIV_EN
            mag_b_q    <= prep_mag_b;
            srca_q     <= srca;
            div_zero_q <= prep_div_zero;
            div_ovf_q  <= prep_div_ovf;
`endif
          end
          ST_CALC: begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
          end
          ST_FINAL: begin
            result <= final_val;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): per-cycle comparison against a
// behavioural model, plus literal vectors. Honours MULDIV_DIV_EN like the RTL.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      op = OP_MUL;
  logic [XLEN-1:0] srca = '0;
  logic [XLEN-1:0] srcb = '0;
  logic            flush = 1'b0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_start = 0;
  bit chk_en = 1'b0;

  // model state: age 0 = idle, 1..XLEN+1 = operation in progress
  int              m_age = 0;
  logic            m_done = 1'b0;
  logic [XLEN-1:0] m_result = '0;
  logic [XLEN-1:0] m_pending = '0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .srca   (srca),
    .srcb   (srcb),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_fn(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (o)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) return (o == OP_REM || o == OP_REMU) ? a : 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF && o == OP_DIV) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF && o == OP_REM) return 32'd0;
        case (o)
          OP_DIV:  p = sa / sb;
          OP_DIVU: p = ua / ub;
          OP_REM:  p = sa % sb;
          default: p = ua % ub;
        endcase
        return p[31:0];
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_age = 0; m_done = 1'b0; m_result = '0;
    end else begin
      m_done = 1'b0;
      if (flush) m_age = 0;
      else if (m_age == XLEN + 1) begin
        m_age = 0; m_done = 1'b1; m_result = m_pending;
      end else if (m_age != 0) m_age++;
      else if (start) begin
        m_age = 1; m_pending = ref_fn(op, srca, srcb);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, (m_age != 0));
      check("done", done, m_done);
      check("result", result, m_result);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; srca = a; srcb = b; t_start = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1; busy_cnt = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      if (done) begin lat = cyc - t_start; break; end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_lit(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int lat, bc;
    issue(o, a, b);
    wait_done(lat, bc);
    check({name, "_result"}, result, exp);
    check({name, "_latency"}, lat, LAT);
    check({name, "_busy_cycles"}, bc, XLEN + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, dcnt;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    reset = 1'b0;
    @(negedge clk);

    run_lit("mul_7xm3",   OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_lit("mulh_min",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_lit("mulhu_max",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_lit("mulhsu_max", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef MULDIV_DIV_EN
    run_lit("div_m7_2",   OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_lit("rem_m7_2",   OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_lit("divu_by0",   OP_DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF);
    run_lit("remu_by0",   OP_REMU,   32'd7,         32'd0,         32'd7);
    run_lit("div_ovf",    OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_lit("rem_ovf",    OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_lit("div_9_3",    OP_DIV,    32'd9,         32'd3,         32'd3);
`else
    run_lit("div_9_3",    OP_DIV,    32'd9,         32'd3,         32'd0);
    run_lit("remu_no_div", OP_REMU,  32'd7,         32'd0,         32'd0);
`endif

    // start while busy is ignored, then start in the done cycle runs back-to-back
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MULHU; srca = 32'h1234_5678; srcb = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    t_start = t_start;
    wait_done(lat, bc);
    check("ignored_start_result", result, 32'hFFFF_FFEB);
    check("ignored_start_latency", lat, LAT);
    issue(OP_MULH, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat, bc);
    check("b2b_result", result, 32'h4000_0000);
    check("b2b_latency", lat, LAT);

    // flush in cycle 10
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    dcnt = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    check("flush_no_done", dcnt, 0);
    check("flush_result_held", result, 32'h4000_0000);

    // reset in cycle 10 of a DIV
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_result", result, 0);
    @(negedge clk);

    // randomized operations with occasional flushes and junk starts
    for (int n = 0; n < 48; n++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'd0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 25)) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 20)) @(negedge clk);
          start = 1'b1; op = 3'($urandom_range(0, 7)); srca = $urandom; srcb = $urandom;
          @(negedge clk);
          start = 1'b0;
        end
        wait_done(lat, bc);
        check("rand_result", result, ref_fn(ro, ra, rb));
        check("rand_latency", lat, LAT);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
